doppel_bildpuffer: RTL



---
 rtl/doppel_bildpuffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/doppel_bildpuffer.sv
// doppel_bildpuffer -- double-buffered framebuffer with frame-synchronous bank swap.
//
// Drawing (x/y/color/write) goes to the back bank. Scan-out (x_data/y_data ->
// pixelData) reads the front bank with one clock of latency. A swap request is
// held in swap_pending and executed on the next frame_start, so the displayed
// image never changes mid-frame.
//
// Optional clear engine, built when the macro BILDPUFFER_CLEAR_EN is defined:
// clear_start latches clear_color and fills the whole back bank, one pixel per
// clock, with busy high for exactly WIDTH*HEIGHT cycles. Without the macro,
// clear_start/clear_color are ignored and busy is tied low.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   x, y, color, write       draw port (back bank); out-of-range writes are dropped
//   x_data, y_data           scan-out address (front bank)
//   pixelData                registered front-bank pixel, 0 for out-of-range reads
//   swap_req, frame_start    swap request pulse, vblank-start pulse
//   swap_pending, front_bank swap state, index of displayed bank
//   clear_start, clear_color clear engine start pulse and fill colour
//   busy                     clear engine active
module doppel_bildpuffer #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int BITSPERPIXEL = 8,
    parameter int XW           = 8,
    parameter int YW           = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XW-1:0]           x,
    input  logic [YW-1:0]           y,
    input  logic [BITSPERPIXEL-1:0] color,
    input  logic                    write,
    input  logic [XW-1:0]           x_data,
    input  logic [YW-1:0]           y_data,
    output logic [BITSPERPIXEL-1:0] pixelData,
    input  logic                    swap_req,
    input  logic                    frame_start,
    output logic                    swap_pending,
    output logic                    front_bank,
    input  logic                    clear_start,
    input  logic [BITSPERPIXEL-1:0] clear_color,
    output logic                    busy
);

    localparam int PIX   = WIDTH * HEIGHT;
    localparam int DEPTH = 2 * PIX;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] PIX_A   = AW'(PIX);
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

    logic [BITSPERPIXEL-1:0] mem [DEPTH];

    logic [AW-1:0] back_base, front_base;
    assign back_base  = front_bank ? '0 : PIX_A;
    assign front_base = front_bank ? PIX_A : '0;

    // Range checks are done on the unwrapped coordinates so that x >= WIDTH can
    // never fold into the next line of the linear address.
    logic draw_ok, rd_ok;
    assign draw_ok = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign rd_ok   = (32'(x_data) < WIDTH) && (32'(y_data) < HEIGHT);

    logic [AW-1:0] draw_addr, rd_addr;
    assign draw_addr = back_base  + AW'(y) * WIDTH_A + AW'(x);
    assign rd_addr   = front_base + AW'(y_data) * WIDTH_A + AW'(x_data);

    logic                    we;
    logic [AW-1:0]           waddr;
    logic [BITSPERPIXEL-1:0] wdata;

`ifdef BILDPUFFER_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [AW-1:0] LAST_A = AW'(PIX - 1);

    logic [0:0]              state;
    logic [AW-1:0]           clr_cnt;
    logic [BITSPERPIXEL-1:0] clr_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            clr_col <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        clr_col <= clear_color;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_A) state <= ST_IDLE;
                    clr_cnt <= clr_cnt + AW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

    // The clear owns the write port while busy; draw writes are dropped then.
    always_comb begin
        we    = 1'b0;
        waddr = draw_addr;
        wdata = color;
        if (busy) begin
            we    = 1'b1;
            waddr = back_base + clr_cnt;
            wdata = clr_col;
        end else if (write && draw_ok) begin
            we = 1'b1;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
    assign busy  = 1'b0;
    assign we    = write && draw_ok;
    assign waddr = draw_addr;
    assign wdata = color;
`endif

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Reads use front_bank as it stands before this edge's swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pixelData <= '0;
        else if (rd_ok) pixelData <= mem[rd_addr];
        else            pixelData <= '0;
    end

    // A swap may not happen mid-clear: the bank being cleared would become visible.
    logic swap_go;
    assign swap_go = frame_start && (swap_pending || swap_req) && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_go) begin
            front_bank   <= ~front_bank;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

endmodule
